// File: rtl/read_responder.sv
// Read-mode responder: fetches start_len bytes of register start_cmd from the
// register file and streams them to the serial transmitter over valid/ready.
module read_responder #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk_usb,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  start_cmd,
  input  logic [15:0] start_len,
  output logic        busy,
  output logic        done,
  output logic [5:0]  reg_cmd,
  output logic [15:0] reg_bytecount,
  output logic        reg_read,
  input  logic [7:0]  reg_data_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned IDX_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   len;
  logic [CNT_W-1:0]   wait_cnt;
  logic [IDX_W:0]     next_idx_c;

  // One bit wider than the index so the end-of-response compare never sees a wrap.
  assign next_idx_c = {1'b0, reg_bytecount} + (IDX_W + 1)'(1);

  always_ff @(posedge clk_usb) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      reg_cmd       <= '0;
      reg_bytecount <= '0;
      reg_read      <= 1'b0;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      len           <= '0;
      wait_cnt      <= '0;
    end else begin
      done     <= 1'b0;
      reg_read <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            reg_cmd       <= start_cmd;
            len           <= start_len;
            reg_bytecount <= '0;
            busy          <= 1'b1;
            if (start_len != '0) begin
              reg_read <= 1'b1;
              state    <= S_FETCH;
            end else begin
              state    <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          wait_cnt <= CNT_W'(RD_LATENCY);
          state    <= S_WAIT;
        end
        // Read data is valid on the last counted cycle after the strobe.
        S_WAIT: begin
          if (wait_cnt == CNT_W'(1)) begin
            tx_data  <= reg_data_out;
            tx_valid <= 1'b1;
            state    <= S_SEND;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_SEND: begin
          if (tx_valid && tx_ready) begin
            tx_valid      <= 1'b0;
            reg_bytecount <= next_idx_c[IDX_W-1:0];
            if (next_idx_c == {1'b0, len}) begin
              state <= S_DONE;
            end else begin
              reg_read <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_read_responder.sv
// Directed bench for read_responder: register file returns 8'hA0 + bytecount
// one cycle after each read strobe.
module tb_read_responder;

  localparam int unsigned RD_LATENCY = 1;

  logic        clk_usb = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  start_cmd;
  logic [15:0] start_len;
  logic        busy;
  logic        done;
  logic [5:0]  reg_cmd;
  logic [15:0] reg_bytecount;
  logic        reg_read;
  logic [7:0]  reg_data_out = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned cyc = 0;
  logic [7:0]  rx_q[$];
  int unsigned hs_cyc[$];
  logic [15:0] rd_idx[$];
  int unsigned done_cnt = 0;

  read_responder #(.RD_LATENCY(RD_LATENCY)) dut (
    .clk_usb       (clk_usb),
    .rst_n         (rst_n),
    .start         (start),
    .start_cmd     (start_cmd),
    .start_len     (start_len),
    .busy          (busy),
    .done          (done),
    .reg_cmd       (reg_cmd),
    .reg_bytecount (reg_bytecount),
    .reg_read      (reg_read),
    .reg_data_out  (reg_data_out),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready)
  );

  always #5 clk_usb = ~clk_usb;

  // Register file model with a one-cycle read latency.
  always @(posedge clk_usb) begin
    if (reg_read) reg_data_out <= 8'hA0 + reg_bytecount[7:0];
  end

  // Transaction monitor, sampled mid-cycle.
  always @(negedge clk_usb) begin
    cyc = cyc + 1;
    if (tx_valid && tx_ready) begin
      rx_q.push_back(tx_data);
      hs_cyc.push_back(cyc);
    end
    if (reg_read) rd_idx.push_back(reg_bytecount);
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk_usb);
    #1;
  endtask

  task automatic clear_mon();
    rx_q.delete();
    hs_cyc.delete();
    rd_idx.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [5:0] cmd, input logic [15:0] len);
    start     = 1'b1;
    start_cmd = cmd;
    start_len = len;
    tick(1);
    start     = 1'b0;
    start_cmd = 6'h00;
    start_len = 16'h0000;
  endtask

  task automatic wait_done(input int unsigned max_cyc);
    for (int i = 0; i < int'(max_cyc); i++) begin
      if (done_cnt != 0) break;
      tick(1);
    end
    chk("done_seen", 32'(done_cnt != 0), 32'd1);
    tick(3);
  endtask

  task automatic wait_valid(input int unsigned max_cyc);
    for (int i = 0; i < int'(max_cyc); i++) begin
      if (tx_valid) break;
      tick(1);
    end
    chk("valid_seen", 32'(tx_valid), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    start_cmd = 6'h00;
    start_len = 16'h0000;
    tx_ready  = 1'b1;
    tick(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_reg_read", 32'(reg_read), 32'd0);
    chk("rst_reg_cmd", 32'(reg_cmd), 32'd0);
    chk("rst_bytecount", 32'(reg_bytecount), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;

    // Idle with tx_ready high and no start.
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_quiet", 32'({busy, done, tx_valid, reg_read}), 32'd0);
    end

    // Basic len=3 response.
    clear_mon();
    do_start(6'h05, 16'd3);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_reg_cmd", 32'(reg_cmd), 32'h05);
    chk("t2_reg_read", 32'(reg_read), 32'd1);
    chk("t2_bytecount0", 32'(reg_bytecount), 32'd0);
    wait_done(40);
    chk("t2_nbytes", 32'(rx_q.size()), 32'd3);
    chk("t2_nreads", 32'(rd_idx.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < rx_q.size()) chk("t2_byte", 32'(rx_q[i]), 32'hA0 + 32'(i));
      if (i < rd_idx.size()) chk("t2_read_idx", 32'(rd_idx[i]), 32'(i));
    end
    for (int i = 1; i < 3; i++) begin
      if (i < hs_cyc.size())
        chk("t2_spacing", hs_cyc[i] - hs_cyc[i-1], 32'(2 + RD_LATENCY));
    end
    chk("t2_done_cnt", done_cnt, 32'd1);
    chk("t2_busy_after", 32'(busy), 32'd0);

    // len=0: no fetch, done two cycles after the start strobe.
    clear_mon();
    do_start(6'h05, 16'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_done_early", 32'(done), 32'd0);
    tick(1);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy_low", 32'(busy), 32'd0);
    tick(1);
    chk("t3_done_once", 32'(done), 32'd0);
    chk("t3_no_reads", 32'(rd_idx.size()), 32'd0);
    chk("t3_no_tx", 32'(rx_q.size()), 32'd0);

    // Backpressure on byte 0 for 10 cycles.
    clear_mon();
    tx_ready = 1'b0;
    do_start(6'h05, 16'd2);
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 32'(tx_valid), 32'd1);
      chk("t4_hold_data", 32'(tx_data), 32'hA0);
      chk("t4_one_read", 32'(rd_idx.size()), 32'd1);
      tick(1);
    end
    tx_ready = 1'b1;
    wait_done(40);
    chk("t4_nbytes", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      chk("t4_byte0", 32'(rx_q[0]), 32'hA0);
      chk("t4_byte1", 32'(rx_q[1]), 32'hA1);
    end
    chk("t4_done_cnt", done_cnt, 32'd1);

    // Start while busy is ignored.
    clear_mon();
    do_start(6'h05, 16'd4);
    tick(2);
    do_start(6'h3F, 16'd9);
    chk("t5_cmd_held", 32'(reg_cmd), 32'h05);
    wait_done(60);
    chk("t5_nbytes", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx_q.size()) chk("t5_byte", 32'(rx_q[i]), 32'hA0 + 32'(i));
    end
    chk("t5_done_cnt", done_cnt, 32'd1);
    chk("t5_cmd_after", 32'(reg_cmd), 32'h05);
    chk("t5_busy_after", 32'(busy), 32'd0);

    // Reset while byte 1 of a len=4 response sits in SEND.
    clear_mon();
    tx_ready = 1'b0;
    do_start(6'h05, 16'd4);
    wait_valid(20);
    tx_ready = 1'b1;
    tick(1);
    tx_ready = 1'b0;
    wait_valid(20);
    chk("t6_byte1", 32'(tx_data), 32'hA1);
    rst_n = 1'b0;
    tick(1);
    chk("t6_rst_outs", 32'({busy, done, tx_valid, reg_read}), 32'd0);
    chk("t6_rst_cmd", 32'(reg_cmd), 32'd0);
    chk("t6_rst_idx", 32'(reg_bytecount), 32'd0);
    chk("t6_rst_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    tick(3);
    chk("t6_no_done", done_cnt, 32'd0);
    chk("t6_quiet", 32'({busy, tx_valid}), 32'd0);
    clear_mon();
    tx_ready = 1'b1;
    do_start(6'h05, 16'd1);
    wait_done(30);
    chk("t6_nbytes", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() == 1) chk("t6_byte0", 32'(rx_q[0]), 32'hA0);
    chk("t6_done_cnt", done_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_responder.md
Name: read_responder

Overview:
- Serial-side responder for READ-mode commands (mode bits 2'b10); the transmit counterpart of the command receive path.
- Accepts a decoded command and byte count, then fetches that many bytes from the register file one at a time.
- Streams the fetched bytes to the USB/serial transmitter over a valid/ready byte handshake.
- Sits between the command decoder (which supplies start/cmd/length), the register file, and the serial TX.

Parameters:
- RD_LATENCY, 1, cycles from reg_read pulse to reg_data_out valid; legal range 1..4.

Ports:
- clk_usb  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle strobe: begin a read response
- start_cmd  input  6  register/command index (cmd byte with mode bits stripped)
- start_len  input  16  number of bytes to return; 0 = none
- busy  output  1  high from the cycle after start is accepted until DONE exits
- done  output  1  one-cycle pulse when a response completes
- reg_cmd  output  6  command index presented to the register file; held for the whole response
- reg_bytecount  output  16  index of the byte being fetched (0-based)
- reg_read  output  1  one-cycle read strobe to the register file
- reg_data_out  input  8  register read data; valid RD_LATENCY cycles after reg_read
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  transmitter accepts tx_data this cycle

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - busy=0, done=0, reg_read=0, tx_valid=0, reg_cmd=0, reg_bytecount=0, tx_data=0.
  - Reset mid-response abandons the response: no done pulse, and any pending tx byte is dropped.
- States: IDLE, FETCH, WAIT, SEND, DONE.
- IDLE:
  - On start=1: latch start_cmd into reg_cmd, latch start_len into an internal len register, set reg_bytecount=0, busy=1.
  - Next state is FETCH if start_len!=0, else DONE.
- FETCH:
  - reg_read=1 for exactly this one cycle, with reg_bytecount equal to the current index.
  - Load the wait counter with RD_LATENCY; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the data is valid (RD_LATENCY cycles after the reg_read cycle): register reg_data_out into tx_data, set tx_valid=1, go to SEND.
  - The first byte therefore appears on tx_valid RD_LATENCY+1 cycles after FETCH.
- SEND:
  - Hold tx_data and tx_valid stable until tx_valid&&tx_ready.
  - On that handshake edge: tx_valid=0 and the index increments.
  - If the incremented index == len, go to DONE; otherwise go to FETCH with reg_bytecount = the new index.
  - tx_valid never deasserts without a handshake, except on reset.
- DONE:
  - done=1 for one cycle, busy=0 at the same edge, return to IDLE.
  - A start in the DONE cycle is ignored.
- Throughput: minimum 2+RD_LATENCY cycles per byte when tx_ready is held high.
- start while busy=1 is ignored: no relatch, and in-flight outputs are unaffected.
- Width rules:
  - Index is 16-bit and compares against len before wrap, so len=65535 sends 65535 bytes with indices 0..65534.
  - The index never wraps inside a response.
- reg_read is asserted only in FETCH; at most one outstanding read at any time.
- tx_ready while tx_valid=0 has no effect.

Test Plan:
- Reset then idle, tx_ready=1, no start -> busy=0, done=0, tx_valid=0, reg_read=0 for 20 cycles.
- start, cmd=6'h05, len=3, regfile returns 8'hA0+bytecount, RD_LATENCY=1, tx_ready=1 -> reg_read pulses with bytecount 0,1,2; TX bytes A0,A1,A2 with 3 cycles between handshakes; single done pulse; busy low after.
- len=0 -> no reg_read, no tx_valid; done pulses 2 cycles after start.
- len=2, tx_ready held low 10 cycles on byte 0 -> tx_data=8'hA0 and tx_valid stable for all 10 cycles; no second reg_read until the handshake; both bytes delivered.
- Second start (cmd=6'h3F) during a len=4 response -> ignored; reg_cmd stays 6'h05; exactly 4 bytes and 1 done.
- rst_n=0 for 1 cycle while in SEND of byte 1 of len=4 -> next cycle all outputs at reset values, no done pulse; a new start(len=1) then completes normally.
